// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Handles byte/halfword extraction with sign/zero extension on loads,
// read-modify-write merging for sub-word stores, and access error detection.
// One request in flight; the response is a single-cycle pulse.
module load_store_unit #(
    parameter int DMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic        error_q;
    logic        write_q;
    logic [31:0] load_data;
    logic        bad_access;
    logic        out_of_range;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the old word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            3'b001: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign out_of_range = {2'b00, req_address[31:2]} >= 32'(DMEM_WORDS);

    // Classify the incoming request as illegal, misaligned or out of range.
    always_comb begin
        bad_access = 1'b0;
        case (req_funct3)
            3'b000:  bad_access = 1'b0;
            3'b001:  bad_access = req_address[0];
            3'b010:  bad_access = (req_address[1:0] != 2'b00);
            3'b100:  bad_access = req_write;
            3'b101:  bad_access = req_write | req_address[0];
            default: bad_access = 1'b1;
        endcase
    end

    // Request sequencing FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= 32'h0000_0000;
            mem_write_enable <= 1'b0;
            mem_address      <= 32'h0000_0000;
            mem_write_data   <= 32'h0000_0000;
            funct3_q         <= 3'b000;
            offset_q         <= 2'b00;
            wdata_q          <= 32'h0000_0000;
            error_q          <= 1'b0;
            write_q          <= 1'b0;
            load_data        <= 32'h0000_0000;
        end else begin
            resp_valid       <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        offset_q    <= req_address[1:0];
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        error_q     <= bad_access | out_of_range;
                        req_ready   <= 1'b0;
                        mem_address <= {2'b00, req_address[31:2]};
                        if (bad_access || out_of_range) begin
                            state <= RESP;
                        end else if (!req_write) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            // Full-word store needs no read; write next cycle.
                            state            <= WRITE;
                            mem_write_enable <= 1'b1;
                            mem_write_data   <= req_wdata;
                        end else begin
                            state <= RMW_READ;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    load_data <= extract_load(mem_read_data, funct3_q, offset_q);
                    state     <= RESP;
                end
                RMW_READ: begin
                    mem_write_data   <= merge_store(mem_read_data, wdata_q, funct3_q, offset_q);
                    mem_write_enable <= 1'b1;
                    state            <= WRITE;
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    // Response fields are only updated here so they hold between pulses.
                    resp_valid  <= 1'b1;
                    resp_error  <= error_q;
                    resp_rdata  <= (error_q || write_q) ? 32'h0000_0000 : load_data;
                    req_ready   <= 1'b1;
                    mem_address <= 32'h0000_0000;
                    state       <= IDLE;
                end
                default: begin
                    req_ready   <= 1'b1;
                    mem_address <= 32'h0000_0000;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:31];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DMEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < 32'd32) ? mem[mem_address[4:0]] : 32'hDEAD_BEEF;

    // Memory model: bench preload port has priority over the DUT write port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write_enable && mem_address < 32'd32) mem[mem_address[4:0]] <= mem_write_data;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request, scramble inputs after acceptance, measure response.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int we_cnt);
        bit found;
        @(negedge clk);
        check_value("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b111;
        req_address = 32'hFFFF_FFFF; req_wdata = ~wd;
        we_cnt = mem_write_enable ? 1 : 0;
        found = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
        check_value("ready_busy", 32'(req_ready), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (!found) begin
                @(posedge clk);
                @(negedge clk);
                if (mem_write_enable) we_cnt++;
                if (resp_valid) begin
                    found = 1'b1; lat = i; rd = resp_rdata; er = resp_error;
                end
            end
        end
        if (!found) begin
            check_value("resp_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check_value("resp_pulse_width", 32'(resp_valid), 32'd0);
            check_value("rdata_hold", resp_rdata, rd);
        end
    endtask

    task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_er,
                           input int exp_lat, input int exp_we);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          we_cnt;
        do_req(w, f3, a, wd, rd, er, lat, we_cnt);
        check_value({tag, ".rdata"}, rd, exp_rd);
        check_value({tag, ".error"}, 32'(er), 32'(exp_er));
        check_value({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_value({tag, ".we_count"}, 32'(we_cnt), 32'(exp_we));
    endtask

    initial begin
        int r1;
        int r2;
        logic [31:0] rd2;
        logic we_seen;
        logic resp_seen;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_address = 32'h0; req_wdata = 32'h0;
        pl_en = 1'b0; pl_idx = 5'd0; pl_data = 32'h0;
        #3;
        check_value("rst.req_ready", 32'(req_ready), 32'd1);
        check_value("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_value("rst.resp_error", 32'(resp_error), 32'd0);
        check_value("rst.resp_rdata", resp_rdata, 32'd0);
        check_value("rst.mem_we", 32'(mem_write_enable), 32'd0);
        check_value("rst.mem_address", mem_address, 32'd0);
        check_value("rst.mem_wdata", mem_write_data, 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Loads with extension
        preload(5'd0, 32'h5566_7788);
        preload(5'd3, 32'h80F1_7F22);
        preload(5'd31, 32'h1357_9BDF);
        run_req("lb_0c",  1'b0, 3'b000, 32'h0C, 32'h0, 32'h0000_0022, 1'b0, 2, 0);
        run_req("lb_0f",  1'b0, 3'b000, 32'h0F, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
        run_req("lbu_0f", 1'b0, 3'b100, 32'h0F, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
        run_req("lh_0e",  1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_80F1, 1'b0, 2, 0);
        run_req("lhu_0e", 1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_80F1, 1'b0, 2, 0);
        run_req("lw_0c",  1'b0, 3'b010, 32'h0C, 32'h0, 32'h80F1_7F22, 1'b0, 2, 0);
        run_req("lb_0d",  1'b0, 3'b000, 32'h0D, 32'h0, 32'h0000_007F, 1'b0, 2, 0);

        // Sub-word stores via read-modify-write
        preload(5'd3, 32'h1122_3344);
        run_req("sb_0d", 1'b1, 3'b000, 32'h0D, 32'hAABB_CCDD, 32'h0, 1'b0, 3, 1);
        check_value("sb_0d.mem", mem[3], 32'h1122_DD44);
        run_req("sh_0e", 1'b1, 3'b001, 32'h0E, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1);
        check_value("sh_0e.mem", mem[3], 32'hBEEF_DD44);
        run_req("sw_14", 1'b1, 3'b010, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1);
        check_value("sw_14.mem", mem[5], 32'hCAFE_F00D);
        run_req("lw_14", 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0);

        // Error cases: one cycle, no write, memory untouched
        run_req("sh_05_mis",  1'b1, 3'b001, 32'h05, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        run_req("lw_02_mis",  1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req("f3_011",     1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req("sb_f3_111",  1'b1, 3'b111, 32'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        run_req("lbu_write",  1'b1, 3'b100, 32'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        run_req("lhu_0d_mis", 1'b0, 3'b101, 32'h0D, 32'h0, 32'h0, 1'b1, 1, 0);
        check_value("err.mem3", mem[3], 32'hBEEF_DD44);
        check_value("err.mem0", mem[0], 32'h5566_7788);

        // Range boundary
        run_req("lw_80_range", 1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req("sw_80_range", 1'b1, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0);
        run_req("lw_7c_last",  1'b0, 3'b010, 32'h7C, 32'h0, 32'h1357_9BDF, 1'b0, 2, 0);

        // Reset during RMW_READ drops the store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_address = 32'h01; req_wdata = 32'h0000_00EE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        we_seen = mem_write_enable;
        resp_seen = resp_valid;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we_seen = we_seen | mem_write_enable;
            resp_seen = resp_seen | resp_valid;
        end
        check_value("rst_mid.we", 32'(we_seen), 32'd0);
        check_value("rst_mid.resp", 32'(resp_seen), 32'd0);
        check_value("rst_mid.ready", 32'(req_ready), 32'd1);
        check_value("rst_mid.mem0", mem[0], 32'h5566_7788);

        // Back-to-back with req_valid held: SW then LW
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_address = 32'h00; req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b0; req_wdata = 32'h0;
        check_value("b2b.ready_busy0", 32'(req_ready), 32'd0);
        r1 = 0; r2 = 0; rd2 = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (r1 != 0 && i == r1 + 1) req_valid = 1'b0;
            if (resp_valid) begin
                if (r1 == 0) r1 = i;
                else if (r2 == 0) begin
                    r2 = i;
                    rd2 = resp_rdata;
                end
            end else if (r2 == 0) begin
                check_value("b2b.ready_busy", 32'(req_ready), 32'd0);
            end
        end
        check_value("b2b.first_resp", 32'(r1), 32'd2);
        check_value("b2b.second_resp", 32'(r2), 32'd5);
        check_value("b2b.rdata", rd2, 32'h0BAD_F00D);
        check_value("b2b.mem0", mem[0], 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
